// File: rtl/scs8hd_aoi_pipe.sv
// scs8hd_aoi_pipe: multi-lane AND-OR-INVERT / OR-AND-INVERT block with a
// two-stage valid/ready pipeline and a counter of results taken downstream.
//
// Each lane reduces its A group and its B group in stage 1. In AOI mode the
// reduction is AND. In OAI mode the reduction is OR. Stage 2 combines the
// two partial terms and inverts them: NOR for AOI, NAND for OAI. The beat's
// MODE travels with the data, so consecutive beats may use different modes.
//
// The handshake allows full throughput. Stage 2 frees itself in the same
// cycle that its result is consumed, and stage 1 does the same when it
// advances. A consume, an advance and an accept can therefore all happen on
// one clock edge.

module scs8hd_aoi_pipe #(
   parameter int NA    = 3,
   parameter int NB    = 2,
   parameter int LANES = 4,
   parameter int CNT_W = 16
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                IN_VALID,
   output logic                IN_READY,
   input  logic                MODE,
   input  logic [LANES*NA-1:0] A,
   input  logic [LANES*NB-1:0] B,
   output logic                OUT_VALID,
   input  logic                OUT_READY,
   output logic [LANES-1:0]    Y,
   output logic                OUT_MODE,
   output logic [CNT_W-1:0]    CNT
`ifdef SC_USE_PG_PIN
   ,
   input  logic                vpwr,
   input  logic                vgnd,
   input  logic                vpb,
   input  logic                vnb
`endif
);

`ifndef SC_USE_PG_PIN
   // Without explicit power pins, the rails are plain supply nets.
   supply1 vpwr;
   supply0 vgnd;
   supply1 vpb;
   supply0 vnb;
`endif

   // The rails carry no logic function. They are collected here only so
   // that they are referenced.
   logic pg_unused;
   assign pg_unused = vpwr & vpb & ~vgnd & ~vnb;

   // ------------------------------------------------------------------
   // Pipeline state
   // ------------------------------------------------------------------
   logic             s1_valid_q, s1_valid_d;
   logic [LANES-1:0] s1_pa_q;
   logic [LANES-1:0] s1_pb_q;
   logic             s1_mode_q;

   logic             s2_valid_q, s2_valid_d;
   logic [LANES-1:0] y_q;
   logic             out_mode_q;

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Per-lane next values for stage 1 (taken from the inputs) and for
   // stage 2 (taken from stage 1).
   logic [LANES-1:0] pa_d;
   logic [LANES-1:0] pb_d;
   logic [LANES-1:0] y_d;

   // ------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------
   logic s2_free;
   logic s1_adv;
   logic accept;
   logic consume;

   // Stage 2 can take a new beat if it is empty, or if its beat leaves now.
   assign s2_free  = ~s2_valid_q | OUT_READY;
   assign s1_adv   = s1_valid_q & s2_free;

   // Ready depends only on pipeline state, never on IN_VALID. This avoids a
   // combinational loop with an upstream stage that waits on ready.
   assign IN_READY = ~s1_valid_q | s2_free;
   assign accept   = IN_VALID & IN_READY;
   assign consume  = s2_valid_q & OUT_READY;

   // ------------------------------------------------------------------
   // Per-lane datapath
   // ------------------------------------------------------------------
   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      logic [NA-1:0] a_grp;
      logic [NB-1:0] b_grp;

      assign a_grp = A[gi*NA +: NA];
      assign b_grp = B[gi*NB +: NB];

      // Stage 1 term: AND reduction for AOI, OR reduction for OAI.
      assign pa_d[gi] = MODE ? (|a_grp) : (&a_grp);
      assign pb_d[gi] = MODE ? (|b_grp) : (&b_grp);

      // Stage 2 term: NOR of the two terms for AOI, NAND for OAI.
      assign y_d[gi] = s1_mode_q ? ~(s1_pa_q[gi] & s1_pb_q[gi])
                                 : ~(s1_pa_q[gi] | s1_pb_q[gi]);
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------

   // Stage occupancy. Filling takes priority over draining, so a stage that
   // empties and refills in the same cycle stays valid.
   always_comb begin
      s1_valid_d = s1_valid_q;
      if (accept) begin
         s1_valid_d = 1'b1;
      end else if (s1_adv) begin
         s1_valid_d = 1'b0;
      end

      s2_valid_d = s2_valid_q;
      if (s1_adv) begin
         s2_valid_d = 1'b1;
      end else if (consume) begin
         s2_valid_d = 1'b0;
      end
   end

   // Results-accepted counter. It wraps naturally at 2^CNT_W.
   always_comb begin
      cnt_d = cnt_q;
      if (consume) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   // ------------------------------------------------------------------
   // Registers
   // ------------------------------------------------------------------

   // Stage 1: capture the reduced A/B terms and the mode when a beat is accepted.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         s1_valid_q <= 1'b0;
         s1_pa_q    <= '0;
         s1_pb_q    <= '0;
         s1_mode_q  <= 1'b0;
      end else begin
         s1_valid_q <= s1_valid_d;
         if (accept) begin
            s1_pa_q   <= pa_d;
            s1_pb_q   <= pb_d;
            s1_mode_q <= MODE;
         end
      end
   end

   // Stage 2: load the inverted result only when stage 1 advances.
   // Y therefore never picks up values from an empty stage 1.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         s2_valid_q <= 1'b0;
         y_q        <= '0;
         out_mode_q <= 1'b0;
      end else begin
         s2_valid_q <= s2_valid_d;
         if (s1_adv) begin
            y_q        <= y_d;
            out_mode_q <= s1_mode_q;
         end
      end
   end

   // Accepted-output counter.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign OUT_VALID = s2_valid_q;
   assign Y         = y_q;
   assign OUT_MODE  = out_mode_q;
   assign CNT       = cnt_q;

endmodule

// File: tb/tb_scs8hd_aoi_pipe.sv
// Directed bench for scs8hd_aoi_pipe (LANES=4, NA=3, NB=2, CNT_W=4).
module tb_scs8hd_aoi_pipe;

   localparam int NA    = 3;
   localparam int NB    = 2;
   localparam int LANES = 4;
   localparam int CNT_W = 4;

   logic                CLK;
   logic                RESET;
   logic                IN_VALID;
   logic                IN_READY;
   logic                MODE;
   logic [LANES*NA-1:0] A;
   logic [LANES*NB-1:0] B;
   logic                OUT_VALID;
   logic                OUT_READY;
   logic [LANES-1:0]    Y;
   logic                OUT_MODE;
   logic [CNT_W-1:0]    CNT;

   int checks   = 0;
   int failures = 0;

   // Stream vectors with hand-computed lane results (lane 3 is the MSB).
   logic [11:0] bb_a [8];
   logic [7:0]  bb_b [8];
   logic        bb_m [8];
   logic [3:0]  bb_y [8];

   scs8hd_aoi_pipe #(
      .NA(NA), .NB(NB), .LANES(LANES), .CNT_W(CNT_W)
   ) dut (
      .CLK(CLK), .RESET(RESET),
      .IN_VALID(IN_VALID), .IN_READY(IN_READY), .MODE(MODE),
      .A(A), .B(B),
      .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
      .Y(Y), .OUT_MODE(OUT_MODE), .CNT(CNT)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic m, input logic [11:0] a, input logic [7:0] b);
      IN_VALID = v;
      MODE     = m;
      A        = a;
      B        = b;
   endtask

   // Streams n beats back to back with OUT_READY high. Each cycle it checks
   // ready, the result in flight and the running count.
   task automatic run_stream(input int n, input int cnt_base);
      for (int i = 0; i < n + 2; i++) begin
         check("stream_in_ready", IN_READY, 1);
         if (i < n) drive(1'b1, bb_m[i % 8], bb_a[i % 8], bb_b[i % 8]);
         else       IN_VALID = 1'b0;
         if (i >= 2) begin
            check("stream_out_valid", OUT_VALID, 1);
            check("stream_y", Y, bb_y[(i - 2) % 8]);
            check("stream_out_mode", OUT_MODE, bb_m[(i - 2) % 8]);
            check("stream_cnt", CNT, (cnt_base + i - 2) % 16);
         end else begin
            check("stream_fill_valid", OUT_VALID, 0);
         end
         $display("stream beat %0d: in_ready=%0b out_valid=%0b y=%b mode=%0b cnt=%0d",
                  i, IN_READY, OUT_VALID, Y, OUT_MODE, CNT);
         step();
      end
      IN_VALID = 1'b0;
      check("stream_drained", OUT_VALID, 0);
      check("stream_final_cnt", CNT, (cnt_base + n) % 16);
   endtask

   initial begin
      bb_m[0] = 1'b0; bb_a[0] = 12'hFFF; bb_b[0] = 8'h00; bb_y[0] = 4'b0000;
      bb_m[1] = 1'b1; bb_a[1] = 12'h000; bb_b[1] = 8'hFF; bb_y[1] = 4'b1111;
      bb_m[2] = 1'b0; bb_a[2] = 12'h000; bb_b[2] = 8'hFF; bb_y[2] = 4'b0000;
      bb_m[3] = 1'b1; bb_a[3] = 12'hFFF; bb_b[3] = 8'hFF; bb_y[3] = 4'b0000;
      bb_m[4] = 1'b0; bb_a[4] = 12'h000; bb_b[4] = 8'h00; bb_y[4] = 4'b1111;
      bb_m[5] = 1'b1; bb_a[5] = 12'h249; bb_b[5] = 8'h44; bb_y[5] = 4'b0101;
      bb_m[6] = 1'b0; bb_a[6] = 12'hE38; bb_b[6] = 8'h30; bb_y[6] = 4'b0001;
      bb_m[7] = 1'b1; bb_a[7] = 12'h811; bb_b[7] = 8'hE1; bb_y[7] = 4'b0110;

      // Reset
      RESET = 1'b1; OUT_READY = 1'b1;
      drive(1'b0, 1'b0, 12'h000, 8'h00);
      step(); step();
      check("rst_out_valid", OUT_VALID, 0);
      check("rst_y", Y, 0);
      check("rst_out_mode", OUT_MODE, 0);
      check("rst_cnt", CNT, 0);
      check("rst_in_ready", IN_READY, 1);
      $display("reset: out_valid=%0b y=%b cnt=%0d in_ready=%0b", OUT_VALID, Y, CNT, IN_READY);
      RESET = 1'b0;

      // Single AOI beat
      drive(1'b1, 1'b0, 12'b101_000_011_111, 8'b10_11_01_00);
      step();
      IN_VALID = 1'b0;
      check("aoi_not_yet", OUT_VALID, 0);
      step();
      check("aoi_out_valid", OUT_VALID, 1);
      check("aoi_y", Y, 4'b1010);
      check("aoi_out_mode", OUT_MODE, 0);
      check("aoi_cnt_before", CNT, 0);
      step();
      check("aoi_cnt", CNT, 1);
      check("aoi_drained", OUT_VALID, 0);
      check("aoi_y_hold", Y, 4'b1010);
      $display("aoi: y=%b cnt=%0d", Y, CNT);

      // Single OAI beat
      drive(1'b1, 1'b1, 12'b000_010_001_000, 8'b00_01_00_11);
      step();
      IN_VALID = 1'b0;
      step();
      check("oai_out_valid", OUT_VALID, 1);
      check("oai_y", Y, 4'b1011);
      check("oai_out_mode", OUT_MODE, 1);
      step();
      check("oai_cnt", CNT, 2);
      $display("oai: y=%b cnt=%0d", Y, CNT);

      // 8 beats back to back with alternating modes
      run_stream(8, 2);

      // Backpressure: fill both stages while downstream stalls
      OUT_READY = 1'b0;
      drive(1'b1, 1'b0, 12'b101_000_011_111, 8'b10_11_01_00);      // -> 1010
      step();
      check("bp_ready_s1_only", IN_READY, 1);
      drive(1'b1, 1'b1, 12'b000_010_001_000, 8'b00_01_00_11);      // -> 1011
      step();
      drive(1'b1, 1'b1, 12'h249, 8'h44);                           // -> 0101, held
      for (int k = 0; k < 5; k++) begin
         check("bp_in_ready", IN_READY, 0);
         check("bp_out_valid", OUT_VALID, 1);
         check("bp_y_frozen", Y, 4'b1010);
         check("bp_mode_frozen", OUT_MODE, 0);
         check("bp_cnt", CNT, 10);
         $display("stall %0d: in_ready=%0b out_valid=%0b y=%b", k, IN_READY, OUT_VALID, Y);
         step();
      end
      OUT_READY = 1'b1;
      #1;
      check("bp_release_ready", IN_READY, 1);
      step();
      IN_VALID = 1'b0;
      check("bp_r1_y", Y, 4'b1011);
      check("bp_r1_mode", OUT_MODE, 1);
      check("bp_r1_valid", OUT_VALID, 1);
      step();
      check("bp_r2_y", Y, 4'b0101);
      check("bp_r2_mode", OUT_MODE, 1);
      check("bp_r2_valid", OUT_VALID, 1);
      step();
      check("bp_drained", OUT_VALID, 0);
      check("bp_cnt_final", CNT, 13);
      $display("backpressure done: cnt=%0d", CNT);

      // Reset while two beats are in flight
      drive(1'b1, 1'b0, 12'b101_000_011_111, 8'b10_11_01_00);
      step();
      drive(1'b1, 1'b1, 12'b000_010_001_000, 8'b00_01_00_11);
      step();
      IN_VALID = 1'b0;
      RESET = 1'b1;
      step();
      RESET = 1'b0;
      check("mrst_out_valid", OUT_VALID, 0);
      check("mrst_y", Y, 0);
      check("mrst_out_mode", OUT_MODE, 0);
      check("mrst_cnt", CNT, 0);
      check("mrst_in_ready", IN_READY, 1);
      for (int k = 0; k < 4; k++) begin
         step();
         check("mrst_no_ghost", OUT_VALID, 0);
         check("mrst_cnt_hold", CNT, 0);
      end
      $display("mid-flight reset: out_valid=%0b y=%b cnt=%0d", OUT_VALID, Y, CNT);

      // Counter wrap: 17 results through a 4-bit counter
      run_stream(17, 0);
      check("wrap_cnt", CNT, 1);
      $display("wrap: cnt=%0d", CNT);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
